if_fetch_unit: RTL and testbench

- Instruction-fetch stage: owns the PC and drives the instruction-memory request/acknowledge handshake.
- Presents {pc+4, instruction, valid} to the IF/ID pipeline register each cycle; that register consumes the same freeze/flush controls.
- Handles variable-latency memory, hazard freeze and branch redirect, including a redirect that lands while a fetch is still outstanding.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_pc_register.sv | 47 ++++
 rtl/if_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state codes,
// word size, default reset vector and the PC advance helper.
package if_fetch_unit_pkg;

    // FSM state encoding shared with the pipeline control logic
    localparam logic [1:0] FETCH = 2'd0;   // request outstanding or issuing
    localparam logic [1:0] HOLD  = 2'd1;   // word captured, waiting for freeze to drop
    localparam logic [1:0] DRAIN = 2'd2;   // redirect pending, old request still in flight

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential PC advance; wraps modulo 2^32 with no alignment check
    function automatic logic [31:0] pc_add(input logic [31:0] pc,
                                           input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Fetch PC register: next-PC selection (branch / sequential / hold) and
// capture of the in-flight address when a redirect lands mid-fetch.
module if_pc_register
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_branch,
    input  logic        advance,
    input  logic        capture_old,
    input  logic [31:0] branch_addr,
    output logic [31:0] fetch_pc,
    output logic [31:0] old_pc,
    output logic [31:0] next_seq_pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    // Sequential successor of the current fetch address
    always_comb begin
        next_seq_pc = pc_add(fetch_pc, STEP);
    end

    // Fetch PC update: redirect wins over sequential advance, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (load_branch) begin
            fetch_pc <= branch_addr;
        end else if (advance) begin
            fetch_pc <= next_seq_pc;
        end
    end

    // Remember the address of the request being drained after a redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_pc <= RESET_PC;
        end else if (capture_old) begin
            old_pc <= fetch_pc;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// presents {pc+step, instruction, valid} to the IF/ID register. Handles
// variable memory latency, hazard freeze and branch redirect, including a
// redirect that arrives while a fetch is still outstanding.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = WORD_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        if_valid
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] hold_instr;
    logic [31:0] fetch_pc;
    logic [31:0] old_pc;
    logic [31:0] next_seq_pc;
    logic        load_branch;
    logic        advance;
    logic        capture_old;
    logic        capture_hold;

    if_pc_register #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .load_branch (load_branch),
        .advance     (advance),
        .capture_old (capture_old),
        .branch_addr (branch_addr),
        .fetch_pc    (fetch_pc),
        .old_pc      (old_pc),
        .next_seq_pc (next_seq_pc)
    );

    // Next-state and PC control; branch_taken outranks freeze everywhere
    always_comb begin
        state_next   = state;
        load_branch  = 1'b0;
        advance      = 1'b0;
        capture_old  = 1'b0;
        capture_hold = 1'b0;
        case (state)
            FETCH: begin
                if (branch_taken) begin
                    load_branch = 1'b1;
                    if (!imem_ack) begin
                        // request still in flight: keep presenting its address
                        capture_old = 1'b1;
                        state_next  = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (!freeze) begin
                        advance = 1'b1;
                    end else begin
                        capture_hold = 1'b1;
                        state_next   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    load_branch = 1'b1;
                    state_next  = FETCH;
                end else if (!freeze) begin
                    advance    = 1'b1;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (branch_taken) begin
                    load_branch = 1'b1;
                end
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Memory request and IF/ID output muxing
    always_comb begin
        imem_req        = 1'b0;
        imem_addr       = fetch_pc;
        if_valid        = 1'b0;
        instruction_out = '0;
        pc_out          = next_seq_pc;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && !branch_taken) begin
                    if_valid        = 1'b1;
                    instruction_out = imem_rdata;
                end
            end
            HOLD: begin
                instruction_out = hold_instr;
                if_valid        = !branch_taken;
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = old_pc;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
        // reset abandons any outstanding request immediately
        if (rst) begin
            imem_req        = 1'b0;
            if_valid        = 1'b0;
            instruction_out = '0;
        end
    end

    // Capture the fetched word when it arrives during a freeze
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_instr <= '0;
        end else if (capture_hold) begin
            hold_instr <= imem_rdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected fetch
// addresses and IF/ID outputs; a monitor pops and compares on every
// accepted request and every valid output cycle.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        if_valid;

    int          compared = 0;
    int          mismatched = 0;
    logic        mem_en = 1'b0;
    int          ws = 0;
    int          cnt = 0;

    logic [31:0] addr_q[$];
    out_t        out_q[$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_addr;
    out_t        exp_out;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .if_valid        (if_valid)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ws wait cycles, data = addr ^ MASK
    assign imem_ack   = mem_en && imem_req && (cnt >= ws);
    assign imem_rdata = imem_addr ^ MASK;

    always @(posedge clk) begin
        if (!mem_en || !imem_req || imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ MASK;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] instr);
        out_t o;
        o.pc = pc;
        o.instr = instr;
        out_q.push_back(o);
    endtask

    // Sequential run of n fetches from start with the given wait states
    task automatic stream(input int n, input logic [31:0] start, input int w);
        ws = w;
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(start + 32'(4 * i));
            push_out(start + 32'(4 * i + 4), word(start + 32'(4 * i)));
        end
        repeat (n * (w + 1)) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_en = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc_out", pc_out, 32'h4);
        check("rst_instr", instruction_out, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        mem_en = 1'b1;
        ws = 0;
    endtask

    task automatic check_drained(input string name);
        check({name, "_addr_q_left"}, 32'(addr_q.size()), 32'd0);
        check({name, "_out_q_left"}, 32'(out_q.size()), 32'd0);
        addr_q.delete();
        out_q.delete();
    endtask

    // Monitor: address stability, accepted fetch addresses, IF/ID outputs
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && pend)
                check("addr_stable", imem_addr, pend_addr);
            if (imem_req && imem_ack) begin
                if (addr_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL fetch_addr: unexpected ack at addr %h, none expected at %0t", imem_addr, $time);
                end else begin
                    exp_addr = addr_q.pop_front();
                    check("fetch_addr", imem_addr, exp_addr);
                end
            end
            if (if_valid) begin
                if (out_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL if_out: unexpected valid pc_out=%h instr=%h, none expected at %0t", pc_out, instruction_out, $time);
                end else begin
                    exp_out = out_q.pop_front();
                    check("pc_out", pc_out, exp_out.pc);
                    check("instruction_out", instruction_out, exp_out.instr);
                end
            end
            pend = imem_req && !imem_ack;
            pend_addr = imem_addr;
        end
    end

    initial begin
        cyc();

        // zero-wait stream, then 2-wait-state fetches
        do_reset();
        stream(5, 32'h0, 0);
        stream(2, 32'h14, 2);
        mem_en = 1'b0;
        cyc();
        check_drained("stream");

        // freeze for 3 cycles coinciding with the ack of addr 8
        do_reset();
        stream(2, 32'h0, 0);
        addr_q.push_back(32'h8);
        repeat (4) push_out(32'hC, word(32'h8));
        freeze = 1'b1;
        repeat (3) cyc();
        freeze = 1'b0;
        @(negedge clk);
        check("hold_no_req", 32'(imem_req), 32'd0);
        cyc();
        addr_q.push_back(32'hC);
        push_out(32'h10, word(32'hC));
        cyc();
        mem_en = 1'b0;
        cyc();
        check_drained("freeze");

        // redirect one cycle into a 3-wait request for 0x20
        do_reset();
        stream(8, 32'h0, 0);
        ws = 3;
        addr_q.push_back(32'h20);
        cyc();
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        cyc();
        branch_taken = 1'b0;
        addr_q.push_back(32'h100);
        push_out(32'h104, word(32'h100));
        @(negedge clk);
        check("drain_addr", imem_addr, 32'h20);
        check("drain_req", 32'(imem_req), 32'd1);
        repeat (6) cyc();
        mem_en = 1'b0;
        cyc();
        check_drained("drain");

        // redirect with same-cycle ack at 0x40
        do_reset();
        stream(16, 32'h0, 0);
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        addr_q.push_back(32'h40);
        cyc();
        branch_taken = 1'b0;
        addr_q.push_back(32'h200);
        push_out(32'h204, word(32'h200));
        cyc();
        mem_en = 1'b0;
        cyc();
        check_drained("branch_ack");

        // reset during outstanding 0x80 request, then PC wrap
        do_reset();
        stream(32, 32'h0, 0);
        mem_en = 1'b0;
        @(negedge clk);
        check("pending_addr", imem_addr, 32'h80);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_valid", 32'(if_valid), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        mem_en = 1'b1;
        ws = 0;
        addr_q.push_back(32'h0);
        push_out(32'h4, word(32'h0));
        cyc();
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFC;
        addr_q.push_back(32'h4);
        cyc();
        branch_taken = 1'b0;
        addr_q.push_back(32'hFFFF_FFFC);
        push_out(32'h0, word(32'hFFFF_FFFC));
        addr_q.push_back(32'h0);
        push_out(32'h4, word(32'h0));
        cyc();
        cyc();
        mem_en = 1'b0;
        cyc();
        check_drained("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
